factorial_dispatch: RTL and testbench
=====================================

// Module: factorial_dispatch
// PURPOSE
//   Upstream feeder for the factorial engine. Buffers operand requests from a
//   ready/valid source in a small FIFO. Issues them one at a time to the
//   engine's in_data/in_valid. Keeps at most one request outstanding: it waits
//   for the engine's out_valid before issuing the next. Sits between the host
//   request path and the engine's dut modport.
// PARAMETERS
//   IN_DATA_WD  4  operand width; must match the engine's IN_DATA_WD
//   DEPTH       4  FIFO entries; power of 2, >= 2
//   CNT_WD      $clog2(DEPTH)+1  localparam, width of occupancy count
// PORTS
//   clk           in   1           clock, all logic on rising edge
//   resetn        in   1           asynchronous, active-low reset
//   s_data        in   IN_DATA_WD  request operand from host
//   s_valid       in   1           host request valid
//   s_ready       out  1           FIFO can accept; = !full (from count only)
//   f_in_data     out  IN_DATA_WD  operand to engine in_data (registered)
//   f_in_valid    out  1           one-cycle issue pulse to engine in_valid (registered)
//   f_out_valid   in   1           engine out_valid (result done)
//   f_out_busy    in   1           engine out_busy
//   count         out  CNT_WD      FIFO occupancy 0..DEPTH
//   pending       out  1           request issued, result not yet seen
//   err_spurious  out  1           sticky: f_out_valid seen while not pending
// BEHAVIOUR
//   Reset (async assert, sync deassert to the clock edge):
//     FIFO empty, rd/wr pointers 0, state IDLE.
//     f_in_data=0, f_in_valid=0, count=0, pending=0, err_spurious=0, s_ready=1.
//   Push: occurs on s_valid && s_ready. Data is written at the wr pointer,
//     which then wraps modulo DEPTH. There is no bypass: an entry pushed at
//     edge N is visible to dispatch only after edge N.
//   Full: count==DEPTH -> s_ready=0. s_valid is held off; data is neither
//     dropped nor overwritten. A pop in the same cycle does NOT raise s_ready.
//   Push and pop in the same cycle: count is unchanged; both pointers advance.
//   FSM (states IDLE, ISSUE, WAIT):
//     IDLE:  if count!=0 && !f_out_busy -> ISSUE. At that edge:
//            f_in_data<=head, f_in_valid<=1, pop head.
//            Otherwise stay in IDLE.
//     ISSUE: f_in_valid is high for exactly this cycle. Next edge:
//            f_in_valid<=0, pending<=1, go to WAIT.
//     WAIT:  hold until f_out_valid=1. Then pending<=0 and go to IDLE.
//            f_out_busy is ignored in this state.
//   Latency: with the engine idle and the FIFO empty, a push at edge N gives
//     f_in_valid=1 in the cycle after edge N+1. Back-to-back issues are
//     separated by at least one IDLE cycle after f_out_valid.
//   f_in_data holds its last value after f_in_valid drops.
//   f_out_valid in IDLE or ISSUE: ignored for flow control and sets
//     err_spurious=1. err_spurious is cleared only by reset.
//   Ordering: strict FIFO. Issue order equals accept order.
//   Reset mid-operation: queued entries are discarded and the FSM returns to
//     IDLE. The engine shares resetn, so there is no result to await.
// TESTING
//   1. Release reset, no stimulus -> s_ready=1, count=0, f_in_valid=0,
//      pending=0, err_spurious=0.
//   2. Push 4'd5 with engine idle -> f_in_valid=1 for one cycle, 2 cycles
//      after push, f_in_data=5, pending=1. Drive f_out_valid -> pending=0.
//   3. f_out_busy=1; push 1,2,3,4 -> count=4, s_ready=0, a 5th s_valid is
//      held. Drop busy and return f_out_valid per issue -> issues 1,2,3,4
//      in order, then the 5th.
//   4. count=2 in WAIT; push on the same edge the FSM pops (IDLE->ISSUE) ->
//      count stays 2, order preserved.
//   5. Assert resetn=0 during WAIT with count=3 -> count=0, pending=0,
//      f_in_valid=0 immediately; no issue after deassert until a new push.
//   6. Pulse f_out_valid in IDLE -> err_spurious=1 and stays 1 across later
//      traffic until reset.

Source files
------------

// File: rtl/factorial_dispatch.sv
// Request feeder for the factorial engine: a small FIFO in front of a
// one-outstanding issue FSM that pulses operands into the engine.
module factorial_dispatch #(
    parameter int IN_DATA_WD = 4,
    parameter int DEPTH      = 4,
    localparam int CNT_WD    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    // Host side: a request transfers on any rising edge where s_valid && s_ready;
    // the host holds s_valid/s_data stable until then, and s_ready never
    // depends on s_valid.
    input  logic [IN_DATA_WD-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    // Engine side
    output logic [IN_DATA_WD-1:0] f_in_data,
    output logic                  f_in_valid,
    input  logic                  f_out_valid,
    input  logic                  f_out_busy,
    // Status
    output logic [CNT_WD-1:0]     count,
    output logic                  pending,
    output logic                  err_spurious,
    output logic [1:0]            dbg_state
);

    localparam int PTR_WD = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state;
    logic [IN_DATA_WD-1:0] mem [DEPTH];
    logic [PTR_WD-1:0]     wr_ptr;
    logic [PTR_WD-1:0]     rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;

    // Readiness comes from the registered count only, so a same-cycle pop
    // never opens a slot for the host until the following cycle.
    assign s_ready    = (count != CNT_WD'(DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = s_valid && s_ready;
    assign pop        = (state == IDLE) && !fifo_empty && !f_out_busy;
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WD'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WD'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_WD'(1);
            end else if (pop && !push) begin
                count <= count - CNT_WD'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            f_in_data    <= '0;
            f_in_valid   <= 1'b0;
            pending      <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            // A result outside WAIT has no request to belong to.
            if (f_out_valid && (state != WAIT)) begin
                err_spurious <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        f_in_data  <= mem[rd_ptr];
                        f_in_valid <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    f_in_valid <= 1'b0;
                    pending    <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (f_out_valid) begin
                        pending <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    f_in_valid <= 1'b0;
                    pending    <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_factorial_dispatch.sv
// Directed bench for factorial_dispatch: reset, single issue, full FIFO,
// simultaneous push/pop, mid-operation reset and the sticky spurious flag.
module tb_factorial_dispatch;

    logic       clk;
    logic       resetn;
    logic [3:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] f_in_data;
    logic       f_in_valid;
    logic       f_out_valid;
    logic       f_out_busy;
    logic [2:0] count;
    logic       pending;
    logic       err_spurious;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    factorial_dispatch #(.IN_DATA_WD(4), .DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .f_in_data    (f_in_data),
        .f_in_valid   (f_in_valid),
        .f_out_valid  (f_out_valid),
        .f_out_busy   (f_out_busy),
        .count        (count),
        .pending      (pending),
        .err_spurious (err_spurious),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Holds s_valid until the request is taken (bounded).
    task automatic push(input logic [3:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        s_valid = 1'b0;
    endtask

    // Returns in the ISSUE cycle, or with ok=0 when the bound runs out.
    task automatic wait_issue(output logic [3:0] d, output bit ok);
        int n;
        n = 0;
        while (!f_in_valid && n < 50) begin
            tick();
            n++;
        end
        ok = f_in_valid;
        d  = f_in_data;
    endtask

    // Called in the ISSUE cycle: move into WAIT, then return a result.
    task automatic complete();
        tick();
        f_out_valid = 1'b1;
        tick();
        f_out_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (s_ready !== 1'b1 || count !== 3'd0 || f_in_valid !== 1'b0 ||
            pending !== 1'b0 || err_spurious !== 1'b0 || f_in_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: s_ready=%b count=%0d f_in_valid=%b pending=%b err=%b data=%0d, want 1 0 0 0 0 0",
                     s_ready, count, f_in_valid, pending, err_spurious, f_in_data);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_fsm: state=%0d want 0", dbg_state);
        end
    endtask

    task automatic test_single();
        push(4'd5);
        checks++;
        if (f_in_valid !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_no_bypass: f_in_valid=%b count=%0d want 0 1", f_in_valid, count);
        end
        tick();
        checks++;
        if (f_in_valid !== 1'b1 || f_in_data !== 4'd5 || count !== 3'd0) begin
            errors++;
            $display("FAIL single_issue: f_in_valid=%b data=%0d count=%0d want 1 5 0", f_in_valid, f_in_data, count);
        end
        tick();
        checks++;
        if (f_in_valid !== 1'b0 || pending !== 1'b1 || f_in_data !== 4'd5 || dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL single_wait: f_in_valid=%b pending=%b data=%0d state=%0d want 0 1 5 2",
                     f_in_valid, pending, f_in_data, dbg_state);
        end
        f_out_valid = 1'b1;
        tick();
        f_out_valid = 1'b0;
        checks++;
        if (pending !== 1'b0 || dbg_state !== 2'd0 || err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL single_done: pending=%b state=%0d err=%b want 0 0 0", pending, dbg_state, err_spurious);
        end
    endtask

    task automatic test_full();
        logic [3:0] d;
        bit ok;
        f_out_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push(4'(i));
            exp_q.push_back(4'(i));
        end
        checks++;
        if (count !== 3'd4 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_count: count=%0d s_ready=%b want 4 0", count, s_ready);
        end
        s_data  = 4'd9;
        s_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if (count !== 3'd4 || s_ready !== 1'b0 || f_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: count=%0d s_ready=%b f_in_valid=%b want 4 0 0", count, s_ready, f_in_valid);
        end
        f_out_busy = 1'b0;
        tick();
        checks++;
        if (f_in_valid !== 1'b1 || f_in_data !== exp_q[0] || count !== 3'd3 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_no_push: f_in_valid=%b data=%0d count=%0d s_ready=%b want 1 %0d 3 1",
                     f_in_valid, f_in_data, count, s_ready, exp_q[0]);
        end
        void'(exp_q.pop_front());
        tick();
        s_valid = 1'b0;
        exp_q.push_back(4'd9);
        checks++;
        if (count !== 3'd4 || pending !== 1'b1) begin
            errors++;
            $display("FAIL full_refill: count=%0d pending=%b want 4 1", count, pending);
        end
        f_out_valid = 1'b1;
        tick();
        f_out_valid = 1'b0;
        while (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            wait_issue(d, ok);
            checks++;
            if (!ok || d !== e) begin
                errors++;
                $display("FAIL full_order: got=%0d issued=%b want %0d", d, ok, e);
            end
            complete();
        end
        checks++;
        if (count !== 3'd0 || err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: count=%0d err=%b want 0 0", count, err_spurious);
        end
    endtask

    task automatic test_push_pop();
        logic [3:0] d;
        bit ok;
        push(4'd7);
        wait_issue(d, ok);
        checks++;
        if (!ok || d !== 4'd7) begin
            errors++;
            $display("FAIL pp_first: got=%0d issued=%b want 7", d, ok);
        end
        tick();
        push(4'd8);
        push(4'd9);
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd9);
        checks++;
        if (count !== 3'd2 || pending !== 1'b1 || dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL pp_setup: count=%0d pending=%b state=%0d want 2 1 2", count, pending, dbg_state);
        end
        f_out_valid = 1'b1;
        tick();
        f_out_valid = 1'b0;
        s_data  = 4'd10;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        exp_q.push_back(4'd10);
        checks++;
        if (count !== 3'd2 || f_in_valid !== 1'b1 || f_in_data !== exp_q[0]) begin
            errors++;
            $display("FAIL pp_same_edge: count=%0d f_in_valid=%b data=%0d want 2 1 %0d",
                     count, f_in_valid, f_in_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        complete();
        while (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            wait_issue(d, ok);
            checks++;
            if (!ok || d !== e) begin
                errors++;
                $display("FAIL pp_order: got=%0d issued=%b want %0d", d, ok, e);
            end
            complete();
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] d;
        bit ok;
        bit seen;
        push(4'd1);
        wait_issue(d, ok);
        tick();
        push(4'd2);
        push(4'd3);
        push(4'd4);
        checks++;
        if (count !== 3'd3 || pending !== 1'b1) begin
            errors++;
            $display("FAIL mr_setup: count=%0d pending=%b want 3 1", count, pending);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || pending !== 1'b0 || f_in_valid !== 1'b0 || s_ready !== 1'b1 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL mr_async: count=%0d pending=%b f_in_valid=%b s_ready=%b state=%0d want 0 0 0 1 0",
                     count, pending, f_in_valid, s_ready, dbg_state);
        end
        tick();
        tick();
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (f_in_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL mr_no_issue: issued=%b count=%0d want 0 0", seen, count);
        end
        push(4'd6);
        wait_issue(d, ok);
        checks++;
        if (!ok || d !== 4'd6) begin
            errors++;
            $display("FAIL mr_restart: got=%0d issued=%b want 6", d, ok);
        end
        complete();
    endtask

    task automatic test_spurious();
        logic [3:0] d;
        bit ok;
        checks++;
        if (err_spurious !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL sp_before: err=%b state=%0d want 0 0", err_spurious, dbg_state);
        end
        f_out_valid = 1'b1;
        tick();
        f_out_valid = 1'b0;
        checks++;
        if (err_spurious !== 1'b1 || dbg_state !== 2'd0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL sp_set: err=%b state=%0d pending=%b want 1 0 0", err_spurious, dbg_state, pending);
        end
        push(4'd3);
        wait_issue(d, ok);
        complete();
        checks++;
        if (err_spurious !== 1'b1 || !ok || d !== 4'd3) begin
            errors++;
            $display("FAIL sp_sticky: err=%b got=%0d issued=%b want 1 3 1", err_spurious, d, ok);
        end
        do_reset();
        checks++;
        if (err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL sp_clear: err=%b want 0", err_spurious);
        end
    endtask

    initial begin
        resetn      = 1'b0;
        s_data      = '0;
        s_valid     = 1'b0;
        f_out_valid = 1'b0;
        f_out_busy  = 1'b0;
        #22;
        resetn = 1'b1;
        tick();
        test_reset();
        test_single();
        test_full();
        test_push_pop();
        test_mid_reset();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
